// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG       = 0;

  // Width of a countdown able to hold PIPE_DEPTH+LOAD_EXTRA (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned pipe_depth,
                                            input int unsigned load_extra);
    int unsigned w;
    w = $clog2(pipe_depth + load_extra + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: cycles remaining until its register's pending write is readable.
module hazard_scoreboard_entry
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = cnt_width(2, 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // A fresh record overrides the decrement of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register pending-write timers, per-source compare, stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned LOAD_EXTRA  = 1,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          forward_en,
  input  logic                          issue_valid,
  input  logic                          issue_flush,
  input  logic [REG_ADDR_W-1:0]         issue_dest,
  input  logic                          issue_wb_en,
  input  logic                          issue_mem_r_en,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  output logic [NUM_SRC-1:0]            src_hazard,
  output logic                          hazard_detected,
  output logic                          pending_any,
  output logic [STALL_CNT_W-1:0]        stall_count
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned CNT_W    = cnt_width(PIPE_DEPTH, LOAD_EXTRA);

  localparam logic [CNT_W-1:0]      ALU_VAL   = CNT_W'(PIPE_DEPTH);
  localparam logic [CNT_W-1:0]      LOAD_VAL  = CNT_W'(PIPE_DEPTH + LOAD_EXTRA);
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic [CNT_W-1:0]      w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy;
  logic [NUM_SRC-1:0]    w_src_hazard;
  logic                  w_hazard;
  logic                  w_rec;
  logic [CNT_W-1:0]      w_rec_val;
  logic [STALL_CNT_W-1:0] r_stall_count;

  assign w_rec     = issue_valid & ~issue_flush & ~w_hazard & issue_wb_en &
                     (issue_dest != ZERO_ADDR);
  assign w_rec_val = issue_mem_r_en ? LOAD_VAL : ALU_VAL;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    hazard_scoreboard_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_rec && (issue_dest == REG_ADDR_W'(r))),
      .i_load_val (w_rec_val),
      .o_cnt      (w_cnt[r]),
      .o_busy     (w_busy[r])
    );
  end

  // Hazards read the pre-edge timers, so a source matching its own dest sees the old value.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_W-1:0] w_addr;
    logic [CNT_W-1:0]      w_src_cnt;
    logic                  w_pending;

    assign w_addr          = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
    assign w_src_cnt       = w_cnt[w_addr];
    // With forwarding only the load-latency tail above PIPE_DEPTH is unreachable.
    assign w_pending       = forward_en ? (w_src_cnt > ALU_VAL) : (w_src_cnt != '0);
    assign w_src_hazard[i] = src_used[i] & (w_addr != ZERO_ADDR) & w_pending;
  end

  assign w_hazard = issue_valid & ~issue_flush & (|w_src_hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_hazard && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign src_hazard      = w_src_hazard;
  assign hazard_detected = w_hazard;
  assign pending_any     = |w_busy;
  assign stall_count     = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table, reset-mid-stall sequence and random run against a per-register timer model.
module tb_hazard_scoreboard;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned PD = 2;
  localparam int unsigned LE = 1;
  localparam int unsigned SW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           forward_en = 1'b0;
  logic           issue_valid = 1'b0;
  logic           issue_flush = 1'b0;
  logic [AW-1:0]  issue_dest = '0;
  logic           issue_wb_en = 1'b0;
  logic           issue_mem_r_en = 1'b0;
  logic [NS*AW-1:0] src_addr = '0;
  logic [NS-1:0]  src_used = '0;
  logic [NS-1:0]  src_hazard;
  logic           hazard_detected;
  logic           pending_any;
  logic [SW-1:0]  stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_ADDR_W  (AW),
    .NUM_SRC     (NS),
    .PIPE_DEPTH  (PD),
    .LOAD_EXTRA  (LE),
    .STALL_CNT_W (SW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .forward_en      (forward_en),
    .issue_valid     (issue_valid),
    .issue_flush     (issue_flush),
    .issue_dest      (issue_dest),
    .issue_wb_en     (issue_wb_en),
    .issue_mem_r_en  (issue_mem_r_en),
    .src_addr        (src_addr),
    .src_used        (src_used),
    .src_hazard      (src_hazard),
    .hazard_detected (hazard_detected),
    .pending_any     (pending_any),
    .stall_count     (stall_count)
  );

  typedef struct {
    bit       fwd, valid, flush, wb, mem;
    int       dest, s0, s1, used;
    int       e_src;
    bit       e_haz, e_pend;
    int       e_stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit fwd, bit valid, bit flush, bit wb, bit mem, int dest,
                              int s0, int s1, int used, int e_src, bit e_haz, bit e_pend,
                              int e_stall);
    vec_t v;
    v.fwd = fwd; v.valid = valid; v.flush = flush; v.wb = wb; v.mem = mem;
    v.dest = dest; v.s0 = s0; v.s1 = s1; v.used = used;
    v.e_src = e_src; v.e_haz = e_haz; v.e_pend = e_pend; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit fwd, input bit valid, input bit flush, input bit wb,
                       input bit mem, input int dest, input int s0, input int s1,
                       input int used);
    forward_en     = fwd;
    issue_valid    = valid;
    issue_flush    = flush;
    issue_wb_en    = wb;
    issue_mem_r_en = mem;
    issue_dest     = AW'(dest);
    src_addr       = {AW'(s1), AW'(s0)};
    src_used       = NS'(used);
  endtask

  // Reference model: remaining cycles per register, plain integers.
  int      mc[2**AW];
  longint  mstall;

  initial begin
    string nm;
    int    esrc;
    bit    ehd, rec;
    int    a;
    bit    fwd, valid, flush, wb, mem;
    int    dest, s0, s1, used;

    // Reset held: outputs quiet whatever the inputs.
    drive(0, 1, 0, 1, 1, 5, 5, 5, 3);
    #2;
    chk("reset haz", 64'(hazard_detected), 64'(0));
    chk("reset src", 64'(src_hazard), 64'(0));
    chk("reset pend", 64'(pending_any), 64'(0));
    chk("reset stall", 64'(stall_count), 64'(0));

    //            fwd v  fl wb mem dst s0  s1 used esrc haz pend stall
    tbl.push_back(mk(1, 1, 0, 1, 0,  5,  0,  0, 0, 0, 0, 0, 0)); // fwd ALU r5
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  5,  0, 1, 0, 0, 1, 0)); // use r5: no stall
    tbl.push_back(mk(1, 1, 0, 1, 1,  5,  0,  0, 0, 0, 0, 1, 0)); // fwd load r5
    tbl.push_back(mk(1, 1, 0, 1, 0,  6,  0,  5, 2, 2, 1, 1, 0)); // load-use stall
    tbl.push_back(mk(1, 1, 0, 1, 0,  6,  0,  5, 2, 0, 0, 1, 1)); // released, r6 recorded
    tbl.push_back(mk(0, 1, 0, 1, 0,  7,  0,  0, 0, 0, 0, 1, 1)); // nofwd ALU r7
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  7,  0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  7,  0, 1, 1, 1, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  7,  0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 1, 0,  0,  0,  0, 0, 0, 0, 0, 3)); // dest r0 ignored
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 1, 0,  3,  0,  0, 0, 0, 0, 0, 3)); // ALU r3
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  1,  3, 1, 0, 0, 1, 3)); // src1 unused
    tbl.push_back(mk(0, 1, 1, 1, 1,  9,  0,  0, 0, 0, 0, 1, 3)); // flushed load r9
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  9,  0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 1, 0,  4,  0,  0, 0, 0, 0, 0, 3)); // ALU r4
    tbl.push_back(mk(1, 1, 0, 1, 1,  4,  0,  0, 0, 0, 0, 1, 3)); // load r4 overrides
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  4,  0, 1, 1, 1, 1, 3)); // cnt4=3 > PD
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  4,  0, 1, 1, 1, 1, 4)); // mode switch, cnt4=2
    tbl.push_back(mk(0, 1, 1, 1, 0,  8,  4,  0, 1, 1, 0, 1, 5)); // flush masks hazard
    tbl.push_back(mk(0, 1, 0, 0, 0,  0,  8,  0, 1, 0, 0, 0, 5)); // r8 not recorded
    tbl.push_back(mk(0, 1, 0, 1, 0, 10, 10,  0, 1, 0, 0, 0, 5)); // src==dest: old cnt
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 10,  0, 1, 1, 1, 1, 5));

    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[k]) begin
      drive(tbl[k].fwd, tbl[k].valid, tbl[k].flush, tbl[k].wb, tbl[k].mem, tbl[k].dest,
            tbl[k].s0, tbl[k].s1, tbl[k].used);
      #2;
      nm = $sformatf("row%0d", k);
      chk({nm, " src"}, 64'(src_hazard), 64'(tbl[k].e_src));
      chk({nm, " haz"}, 64'(hazard_detected), 64'(tbl[k].e_haz));
      chk({nm, " pend"}, 64'(pending_any), 64'(tbl[k].e_pend));
      chk({nm, " stall"}, 64'(stall_count), 64'(tbl[k].e_stall));
      @(negedge clk);
    end

    // Reset asserted between edges while a load-use stall is active.
    drive(0, 1, 0, 1, 1, 11, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 11, 0, 1);
    #2;
    chk("midstall haz before", 64'(hazard_detected), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("midstall haz", 64'(hazard_detected), 64'(0));
    chk("midstall pend", 64'(pending_any), 64'(0));
    chk("midstall stall", 64'(stall_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post reset haz", 64'(hazard_detected), 64'(0));
    chk("post reset stall", 64'(stall_count), 64'(0));
    @(negedge clk);

    // Random run from a clean scoreboard.
    foreach (mc[r]) mc[r] = 0;
    mstall = 0;
    fwd = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 15) == 0) fwd = ~fwd;
      valid = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 7) == 0);
      wb    = ($urandom_range(0, 3) != 0);
      mem   = ($urandom_range(0, 2) == 0);
      dest  = $urandom_range(0, 7);
      s0    = $urandom_range(0, 7);
      s1    = $urandom_range(0, 7);
      used  = $urandom_range(0, 3);
      drive(fwd, valid, flush, wb, mem, dest, s0, s1, used);

      esrc = 0;
      for (int i = 0; i < NS; i++) begin
        a = (i == 0) ? s0 : s1;
        if (used[i] && a != 0 && (fwd ? (mc[a] > PD) : (mc[a] != 0))) esrc |= (1 << i);
      end
      ehd = valid && !flush && (esrc != 0);
      rec = valid && !flush && !ehd && wb && dest != 0;

      #2;
      if (src_hazard !== NS'(esrc) || hazard_detected !== ehd) begin
        nm = $sformatf("rand%0d", cyc);
        chk({nm, " src"}, 64'(src_hazard), 64'(esrc));
        chk({nm, " haz"}, 64'(hazard_detected), 64'(ehd));
      end else begin
        chk("rand haz", 64'({src_hazard, hazard_detected}), 64'({NS'(esrc), ehd}));
      end
      chk("rand pend", 64'(pending_any), 64'(mc.sum() != 0));
      chk("rand stall", 64'(stall_count), 64'(mstall));

      for (int r = 0; r < 2**AW; r++) begin
        if (rec && r == dest) mc[r] = mem ? int'(PD + LE) : int'(PD);
        else if (mc[r] > 0) mc[r] = mc[r] - 1;
      end
      if (ehd && mstall < 64'hFFFF_FFFF) mstall = mstall + 1;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
